// File: rtl/xgmii_rx_player.sv
// XGMII receive player: buffers whole frames popped from the rx async FIFO and replays
// each committed frame as a gap-free XGMII word stream, separated by idle words.
module xgmii_rx_player #(
   parameter int unsigned BUF_ADDR_W = 9,
   parameter int unsigned IPG_WORDS  = 1
) (
   input  logic        xgmii_clk,
   input  logic        sys_rst_n,
   input  logic [71:0] fifo_dout,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   output logic [7:0]  xgmii_rxc,
   output logic [63:0] xgmii_rxd,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   localparam int unsigned Depth = 2 ** BUF_ADDR_W;
   localparam logic [71:0] IdleWord = {8'hff, 64'h0707070707070707};

   typedef logic [BUF_ADDR_W-1:0] ptr_t;
   typedef enum logic [1:0] {WStart, WFrame, WDiscard} wr_state_e;
   typedef enum logic [1:0] {PIdle, PPlay, PIpg} pl_state_e;

   localparam ptr_t MaxLen = ptr_t'(Depth - 2);

   function automatic logic ctl_is_term(input logic [7:0] ctl);
      return (ctl != 8'h00) && (ctl != 8'h01);
   endfunction

   logic [71:0] mem [Depth];

   ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   ptr_t        base_q, base_d, pending_q, pending_d;
   ptr_t        free, frame_len, wr_addr;
   wr_state_e   wr_state_q, wr_state_d;
   pl_state_e   pl_state_q, pl_state_d;
   logic        rd_valid_q;
   logic        is_start, is_term;
   logic        wr_en, commit, drop;
   logic        rd_issue, rd_vld_q, emit_term, mem_is_term;
   logic [71:0] rd_data_q, out_q;
   logic [3:0]  ipg_q, ipg_d;
   logic [15:0] frame_cnt_q, drop_cnt_q;

   assign free       = ptr_t'(Depth - 1) - (wr_ptr_q - rd_ptr_q);
   // One popped word may still be in flight, so keep a spare slot for it.
   assign fifo_rd_en = !fifo_empty && (free > ptr_t'(1));

   assign is_start  = (fifo_dout[71:64] == 8'h01) && (fifo_dout[7:0] == 8'hfb);
   assign is_term   = ctl_is_term(fifo_dout[71:64]);
   assign frame_len = wr_ptr_q - base_q;

   always_comb begin
      wr_state_d = wr_state_q;
      wr_ptr_d   = wr_ptr_q;
      base_d     = base_q;
      wr_addr    = wr_ptr_q;
      wr_en      = 1'b0;
      commit     = 1'b0;
      drop       = 1'b0;
      if (rd_valid_q) begin
         case (wr_state_q)
            WStart: begin
               if (is_start) begin
                  wr_en      = 1'b1;
                  base_d     = wr_ptr_q;
                  wr_ptr_d   = wr_ptr_q + ptr_t'(1);
                  wr_state_d = WFrame;
               end else begin
                  wr_state_d = WDiscard;
               end
            end
            WFrame: begin
               if (is_start) begin
                  // Unterminated frame: reuse its space for the new one.
                  drop     = 1'b1;
                  wr_en    = 1'b1;
                  wr_addr  = base_q;
                  wr_ptr_d = base_q + ptr_t'(1);
               end else if (frame_len >= MaxLen) begin
                  drop       = 1'b1;
                  wr_ptr_d   = base_q;
                  wr_state_d = WDiscard;
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + ptr_t'(1);
                  if (is_term) begin
                     commit     = 1'b1;
                     wr_state_d = WStart;
                  end
               end
            end
            WDiscard: begin
               if (is_start) begin
                  wr_en      = 1'b1;
                  base_d     = wr_ptr_q;
                  wr_ptr_d   = wr_ptr_q + ptr_t'(1);
                  wr_state_d = WFrame;
               end else if (is_term) begin
                  wr_state_d = WStart;
               end
            end
            default: wr_state_d = WStart;
         endcase
      end
   end

   assign mem_is_term = ctl_is_term(mem[rd_ptr_q][71:64]);
   assign emit_term   = rd_vld_q && ctl_is_term(rd_data_q[71:64]);

   always_comb begin
      pl_state_d = pl_state_q;
      ipg_d      = ipg_q;
      rd_issue   = 1'b0;
      case (pl_state_q)
         PIdle: begin
            if (pending_q != '0) begin
               rd_issue   = 1'b1;
               pl_state_d = PPlay;
            end
         end
         PPlay: begin
            rd_issue = 1'b1;
            if (mem_is_term) begin
               pl_state_d = PIpg;
               ipg_d      = 4'(IPG_WORDS);
            end
         end
         PIpg: begin
            // IPG_WORDS+1 cycles here plus the idle-state read gives the inter-frame gap.
            if (ipg_q == '0) begin
               pl_state_d = PIdle;
            end else begin
               ipg_d = ipg_q - 4'd1;
            end
         end
         default: pl_state_d = PIdle;
      endcase
      rd_ptr_d  = rd_issue ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      pending_d = pending_q + ptr_t'(commit) - ptr_t'(emit_term);
   end

   always_ff @(posedge xgmii_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= fifo_dout;
      end
   end

   always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_state_q  <= WStart;
         pl_state_q  <= PIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         base_q      <= '0;
         pending_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_data_q   <= '0;
         ipg_q       <= '0;
         out_q       <= IdleWord;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         pl_state_q  <= pl_state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         base_q      <= base_d;
         pending_q   <= pending_d;
         rd_valid_q  <= fifo_rd_en;
         rd_vld_q    <= rd_issue;
         rd_data_q   <= mem[rd_ptr_q];
         ipg_q       <= ipg_d;
         out_q       <= rd_vld_q ? rd_data_q : IdleWord;
         frame_cnt_q <= frame_cnt_q + 16'(emit_term);
         drop_cnt_q  <= drop_cnt_q + 16'(drop);
      end
   end

   assign xgmii_rxc = out_q[71:64];
   assign xgmii_rxd = out_q[63:0];
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_player.sv
// Bench for xgmii_rx_player: FIFO model feeding words, scoreboard of expected replayed words.
module tb_xgmii_rx_player;

   localparam int unsigned AW  = 4;
   localparam int unsigned IPG = 2;
   localparam logic [71:0] IDLE = {8'hff, 64'h0707070707070707};

   logic        clk = 1'b0;
   logic        sys_rst_n;
   logic [71:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  xgmii_rxc;
   logic [63:0] xgmii_rxd;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   xgmii_rx_player #(
      .BUF_ADDR_W(AW),
      .IPG_WORDS (IPG)
   ) dut (
      .xgmii_clk (clk),
      .sys_rst_n (sys_rst_n),
      .fifo_dout (fifo_dout),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .xgmii_rxc (xgmii_rxc),
      .xgmii_rxd (xgmii_rxd),
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt)
   );

   logic [71:0] src_q[$];
   logic [71:0] exp_q[$];
   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   bit in_frame = 1'b0;
   int idle_run = 0;
   int last_gap = -1;
   int first_start_cyc = -1;
   int exp_frames = 0;
   int exp_drops = 0;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [71:0] start_w();
      return {8'h01, $urandom, 24'($urandom), 8'hfb};
   endfunction

   function automatic logic [71:0] data_w();
      return {8'h00, $urandom, $urandom};
   endfunction

   function automatic logic [71:0] term_w();
      return {8'hff, 56'h07070707070707, 8'hfd};
   endfunction

   function automatic logic [71:0] term_f0_w();
      return {8'hf0, 24'h070707, 8'hfd, $urandom};
   endfunction

   task automatic push(input logic [71:0] w, input bit expect_out);
      src_q.push_back(w);
      if (expect_out) exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic push_frame(input int n_data, input bit expect_out);
      push(start_w(), expect_out);
      for (int i = 0; i < n_data; i++) push(data_w(), expect_out);
      push(term_w(), expect_out);
   endtask

   task automatic monitor();
      logic [71:0] obs;
      obs = {xgmii_rxc, xgmii_rxd};
      if (obs === IDLE) begin
         idle_run++;
         chk("frame_contiguous", 72'(in_frame), 72'(0));
      end else begin
         if (obs[71:64] == 8'h01 && obs[7:0] == 8'hfb) begin
            last_gap = idle_run;
            if (first_start_cyc < 0) first_start_cyc = cyc;
         end
         if (exp_q.size() == 0) chk("unexpected_word", obs, IDLE);
         else chk("replay_word", obs, exp_q.pop_front());
         in_frame = (obs[71:64] == 8'h00) || (obs[71:64] == 8'h01);
         idle_run = 0;
      end
   endtask

   // One clock: check outputs at the falling edge, then model the non-FWFT FIFO after the rise.
   task automatic step();
      bit rd;
      @(negedge clk);
      if (sys_rst_n) monitor();
      rd = fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd && src_q.size() > 0) fifo_dout = src_q.pop_front();
      fifo_empty = (src_q.size() == 0);
      cyc++;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         step();
         k++;
      end
      chk(tag, 72'(exp_q.size()), 72'(0));
      steps(IPG + 6);
      chk({tag, "_idle_after"}, {xgmii_rxc, xgmii_rxd}, IDLE);
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_frame_cnt"}, 72'(frame_cnt), 72'(16'(exp_frames)));
      chk({tag, "_drop_cnt"}, 72'(drop_cnt), 72'(16'(exp_drops)));
   endtask

   task automatic do_reset(input string tag);
      sys_rst_n = 1'b0;
      #1;
      chk({tag, "_out_idle"}, {xgmii_rxc, xgmii_rxd}, IDLE);
      exp_frames = 0;
      exp_drops  = 0;
      check_counts(tag);
      steps(2);
      exp_q.delete();
      in_frame        = 1'b0;
      idle_run        = 0;
      last_gap        = -1;
      first_start_cyc = -1;
      sys_rst_n       = 1'b1;
      steps(2);
   endtask

   initial begin
      int t0;
      int k;
      sys_rst_n  = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      steps(3);
      chk("reset_out", {xgmii_rxc, xgmii_rxd}, IDLE);
      chk("reset_rd_en", 72'(fifo_rd_en), 72'(0));
      check_counts("reset");
      sys_rst_n = 1'b1;
      steps(4);
      chk("empty_out", {xgmii_rxc, xgmii_rxd}, IDLE);
      chk("empty_rd_en", 72'(fifo_rd_en), 72'(0));

      // Single 9-word frame; START is due 9 pops + 1 write + 2 read/output cycles later.
      t0 = cyc;
      push_frame(7, 1'b1);
      exp_frames++;
      drain("single");
      chk("single_latency", 72'(first_start_cyc - t0), 72'(12));
      check_counts("single");

      push_frame(7, 1'b1);
      push_frame(4, 1'b1);
      exp_frames += 2;
      drain("b2b");
      chk("b2b_gap", 72'(last_gap), 72'(IPG + 1));
      check_counts("b2b");

      // 20-word frame cannot fit a 16-word buffer; the following frame must survive.
      push_frame(18, 1'b0);
      push_frame(7, 1'b1);
      exp_drops++;
      exp_frames++;
      drain("overflow");
      check_counts("overflow");

      push(data_w(), 1'b0);
      push(data_w(), 1'b0);
      push(term_f0_w(), 1'b0);
      push_frame(7, 1'b1);
      exp_frames++;
      drain("orphan");
      check_counts("orphan");

      push(start_w(), 1'b0);
      for (int i = 0; i < 3; i++) push(data_w(), 1'b0);
      push_frame(7, 1'b1);
      exp_drops++;
      exp_frames++;
      drain("unterm");
      check_counts("unterm");

      // Slide frame 2's terminate across frame 1's replay, including the cycle it is emitted.
      for (int d = 10; d <= 24; d++) begin
         do_reset("sweep_rst");
         push_frame(7, 1'b1);
         push(start_w(), 1'b1);
         for (int i = 0; i < 6; i++) push(data_w(), 1'b1);
         steps(d);
         push(term_w(), 1'b1);
         exp_frames = 2;
         drain("sweep");
         check_counts("sweep");
         chk("sweep_gap_min", 72'(last_gap >= int'(IPG + 1)), 72'(1));
         if (d <= 14) chk("sweep_gap", 72'(last_gap), 72'(IPG + 1));
      end

      // Reset while frame A replays and frame B is half-stored.
      do_reset("pre_mid");
      push_frame(7, 1'b1);
      push(start_w(), 1'b0);
      push(data_w(), 1'b0);
      push(data_w(), 1'b0);
      k = 0;
      while (first_start_cyc < 0 && k < 60) begin
         step();
         k++;
      end
      chk("mid_start_seen", 72'(first_start_cyc >= 0), 72'(1));
      steps(3);
      chk("mid_rd_en", 72'(fifo_rd_en), 72'(0));
      do_reset("mid");
      for (int i = 0; i < 3; i++) push(data_w(), 1'b0);
      push(term_w(), 1'b0);
      push_frame(7, 1'b1);
      exp_frames = 1;
      drain("post_mid");
      check_counts("post_mid");
      chk("fifo_consumed", 72'(src_q.size()), 72'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
